// File: rtl/rename_stage.sv
// rename_stage: single-issue register rename between decode and the issue queue.
// X0-X30 are renamed through a speculative map (SRAT). A committed map (CRAT)
// lets a flush restore the SRAT in a single cycle. X31 (XZR) is never renamed.
//
// Ports:
//   clk, rst_n                  clock (rising edge), async active-low reset
//   in_valid/in_ready           decode handshake
//   in_rd/in_rn/in_rm/in_wen    architectural uop fields
//   alloc_en/alloc_phys/alloc_valid   free-list allocate port
//   free_en/free_phys           free-list return port (combinational)
//   out_valid/out_ready         issue handshake
//   out_prd/out_prn/out_prm/out_old_prd/out_rd/out_wen/out_rn_zr/out_rm_zr
//                               registered renamed uop
//   commit_en/commit_rd/commit_phys/commit_old_phys   ROB retirement
//   rel_en/rel_phys/rel_ready   ROB returns a squashed tag
//   flush                       recovery: SRAT <- CRAT
module rename_stage #(
  parameter int ARCH_REGS = 32,
  parameter int PHYS_REGS = 64,
  localparam int AW = $clog2(ARCH_REGS),
  localparam int PW = $clog2(PHYS_REGS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [AW-1:0] in_rd,
  input  logic [AW-1:0] in_rn,
  input  logic [AW-1:0] in_rm,
  input  logic          in_wen,
  output logic          alloc_en,
  input  logic [PW-1:0] alloc_phys,
  input  logic          alloc_valid,
  output logic          free_en,
  output logic [PW-1:0] free_phys,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [PW-1:0] out_prd,
  output logic [PW-1:0] out_prn,
  output logic [PW-1:0] out_prm,
  output logic [PW-1:0] out_old_prd,
  output logic [AW-1:0] out_rd,
  output logic          out_wen,
  output logic          out_rn_zr,
  output logic          out_rm_zr,
  input  logic          commit_en,
  input  logic [AW-1:0] commit_rd,
  input  logic [PW-1:0] commit_phys,
  input  logic [PW-1:0] commit_old_phys,
  input  logic          rel_en,
  input  logic [PW-1:0] rel_phys,
  output logic          rel_ready,
  input  logic          flush
);

  localparam logic [AW-1:0] XZR       = AW'(ARCH_REGS - 1);
  localparam logic [AW-1:0] INIT_LAST = AW'(ARCH_REGS - 2);

  typedef enum logic [0:0] {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

  state_t        state_r;
  state_t        state_nxt_s;
  logic [AW-1:0] init_cnt_r;
  logic [PW-1:0] srat_r [ARCH_REGS];
  logic [PW-1:0] crat_r [ARCH_REGS];
  logic          need_alloc_s;
  logic          fire_s;
  logic          commit_wr_s;

  // Next state, handshakes and the free-list ports.
  always_comb begin
    state_nxt_s  = state_r;
    in_ready     = 1'b0;
    alloc_en     = 1'b0;
    fire_s       = 1'b0;
    commit_wr_s  = 1'b0;
    rel_ready    = 1'b0;
    free_en      = 1'b0;
    free_phys    = {PW{1'b0}};
    need_alloc_s = in_wen && (in_rd != XZR);
    case (state_r)
      ST_INIT: begin
        // Keep requesting while out of reset; the free list hands out P0..P30.
        alloc_en = rst_n;
        if (alloc_valid && (init_cnt_r == INIT_LAST)) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_INIT;
        end
      end
      ST_RUN: begin
        in_ready    = !flush && (!out_valid || out_ready);
        // alloc_en is a request only; a missing tag simply blocks the fire.
        alloc_en    = in_valid && in_ready && need_alloc_s;
        fire_s      = in_valid && in_ready && (need_alloc_s ? alloc_valid : 1'b1);
        commit_wr_s = commit_en && (commit_rd != XZR);
        rel_ready   = !commit_en;
        if (commit_wr_s) begin
          free_en   = 1'b1;
          free_phys = commit_old_phys;
        end else if (rel_en && rel_ready) begin
          free_en   = 1'b1;
          free_phys = rel_phys;
        end else begin
          free_en   = 1'b0;
          free_phys = {PW{1'b0}};
        end
      end
      default: begin
        state_nxt_s = ST_INIT;
      end
    endcase
  end

  // State register and init counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_INIT;
      init_cnt_r <= {AW{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      if ((state_r == ST_INIT) && alloc_valid) begin
        init_cnt_r <= init_cnt_r + AW'(1);
      end
    end
  end

  // Rename tables: init fill, commit into CRAT, speculative write or flush restore of SRAT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ARCH_REGS; i++) begin
        srat_r[i] <= {PW{1'b0}};
        crat_r[i] <= {PW{1'b0}};
      end
    end else if (state_r == ST_INIT) begin
      if (alloc_valid) begin
        srat_r[init_cnt_r] <= alloc_phys;
        crat_r[init_cnt_r] <= alloc_phys;
      end
    end else begin
      if (commit_wr_s) begin
        crat_r[commit_rd] <= commit_phys;
      end
      if (flush) begin
        // Restore from CRAT, forwarding this cycle's commit.
        for (int i = 0; i < ARCH_REGS; i++) begin
          if (commit_wr_s && (commit_rd == AW'(i))) begin
            srat_r[i] <= commit_phys;
          end else begin
            srat_r[i] <= crat_r[i];
          end
        end
      end else if (fire_s && need_alloc_s) begin
        srat_r[in_rd] <= alloc_phys;
      end
    end
  end

  // Output register towards the issue queue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_prd     <= {PW{1'b0}};
      out_prn     <= {PW{1'b0}};
      out_prm     <= {PW{1'b0}};
      out_old_prd <= {PW{1'b0}};
      out_rd      <= {AW{1'b0}};
      out_wen     <= 1'b0;
      out_rn_zr   <= 1'b0;
      out_rm_zr   <= 1'b0;
    end else if (fire_s) begin
      // Sources read the SRAT before this uop's own destination write.
      out_valid   <= 1'b1;
      out_prn     <= (in_rn == XZR) ? {PW{1'b0}} : srat_r[in_rn];
      out_prm     <= (in_rm == XZR) ? {PW{1'b0}} : srat_r[in_rm];
      out_prd     <= need_alloc_s ? alloc_phys : {PW{1'b0}};
      out_old_prd <= need_alloc_s ? srat_r[in_rd] : {PW{1'b0}};
      out_rd      <= in_rd;
      out_wen     <= need_alloc_s;
      out_rn_zr   <= (in_rn == XZR);
      out_rm_zr   <= (in_rm == XZR);
    end else if (flush || out_ready) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= out_valid;
    end
  end

endmodule
